conv_window_product_gen: RTL and testbench
==========================================

Name: conv_window_product_gen

Overview:
- Front end of the 5x5 convolution datapath.
- Accepts a raster-order pixel stream and holds a 25-entry weight set.
- Keeps KERNEL_SIZE-1 line buffers and a sliding window, and emits 25 registered pixel×weight products with a valid strobe.
- The products feed the pipelined 25-input adder tree; the tree has no backpressure, so this block never stalls its output.

Parameters:
- pic_bits, 2, unsigned pixel width
- weight_bits, 3, signed two's-complement weight width
- kernel_size, 5, window side; only 5 is supported
- kernel_number, 1, carried for width calculation only
- channel, 1, carried for width calculation only
- conv_result_bits, $clog2(kernel_size*kernel_size*kernel_number*channel)+weight_bits+1 (=9), product output width
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse that begins a frame
- w_we  in  1  weight write enable
- w_addr  in  5  weight index 0..24
- w_data  in  weight_bits  signed weight value
- pix_valid  in  1  pixel present
- pix_data  in  pic_bits  unsigned pixel
- pix_ready  out  1  pixel accepted when pix_valid&&pix_ready
- products  out  [conv_result_bits-1:0] x25 (array [24:0])  signed products
- prod_valid  out  1  products hold a complete window
- out_row  out  $clog2(IMG_H)  window top-left row
- out_col  out  $clog2(IMG_W)  window top-left column
- busy  out  1  high while in STREAM
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
Clock and reset:
- Single clock clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge.
- Reset values: state=IDLE; all weights, window registers, line buffers and counters = 0; every output = 0.
- Reset mid-frame abandons the frame. No prod_valid or frame_done is issued after the reset edge.

FSM:
- IDLE -> STREAM on start.
- STREAM -> DONE when the accepted pixel is at (IMG_H-1, IMG_W-1).
- DONE -> IDLE unconditionally.
- DONE lasts one cycle and drives frame_done=1.
- busy=1 only in STREAM.
- start outside IDLE is ignored.

Weights:
- Written only in IDLE: w_we stores w_data into weight[w_addr].
- w_addr>24 is ignored. w_we outside IDLE is ignored.
- Weights persist across frames until rst_n.

Pixel acceptance:
- pix_ready = (state==STREAM).
- Counters row r and col c start at 0 on entry to STREAM.
- Each accept advances c. At c=IMG_W-1, c wraps to 0 and r increments.
- Cycles where pix_valid=0 leave all state unchanged; gaps are allowed anywhere.

Window:
- On each accept, the 5x5 window shifts left one column.
- The new right column (top to bottom) is line-buffer rows r-4..r-1 at column c, followed by pix_data.
- The line buffers are then updated with the pixel.
- window[i][j]: i=0 is the top row, j=0 is the leftmost column.
- Columns left over from the previous row are present while c<4; they are never flagged valid.

Products:
- k = i*5+j.
- products[k] = sign-extended signed(weight[k]) × zero-extended pix, at conv_result_bits.
- Range is -12..9; no saturation is needed.
- Outputs are registered: one cycle after the accept that completes the window at (r,c) with r>=4 and c>=4, prod_valid=1, out_row=r-4, out_col=c-4.
- prod_valid is a single-cycle pulse per window.
- products and out_row/out_col hold their value when prod_valid=0.
- Windows per frame: (IMG_H-4)*(IMG_W-4).

Boundary cases:
- The last pixel's window is issued in the DONE cycle, together with frame_done.
- A start arriving in the DONE cycle is ignored.

Test Plan:
Use IMG_W=IMG_H=8 for all scenarios unless stated.
- Weights all 1, all pixels 3, pix_valid held high -> exactly 16 prod_valid pulses; every product = 9'd3; first pulse one cycle after pixel (4,4) with out_row=0, out_col=0.
- weight[12]=-4, others 0; pixel(r,c)=(r+c)%4 -> window (0,0) products[12]=0; window (0,1) products[12]=9'h1FC (-4); all other products 0.
- Same stream as the previous case with random 1-3 cycle pix_valid gaps -> identical products sequence; each prod_valid exactly one cycle after the completing accept.
- Assert rst_n=0 after 20 accepted pixels -> next cycle prod_valid=0, busy=0, weights read 0; a reloaded full frame then gives correct results.
- w_we during STREAM with w_addr=0, w_data=3 -> weight[0] unchanged; start pulse mid-frame -> counters unaffected.
- Last pixel (7,7) accepted -> next cycle frame_done=1 and prod_valid=1 with out_row=3, out_col=3; busy=0 from that cycle.

Source files
------------

// File: rtl/conv_window_product_gen.sv
// conv_window_product_gen: raster pixel stream in, 5x5 sliding window out as
// 25 registered pixel x weight products with a single-cycle valid strobe.
// Feeds a pipelined adder tree that cannot stall, so there is no output
// backpressure: every completed window is issued exactly once.
module conv_window_product_gen #(
  parameter int pic_bits         = 2,
  parameter int weight_bits      = 3,
  parameter int kernel_size      = 5,
  parameter int kernel_number    = 1,
  parameter int channel          = 1,
  parameter int conv_result_bits = $clog2(kernel_size*kernel_size*kernel_number*channel)
                                   + weight_bits + 1,
  parameter int IMG_W            = 28,
  parameter int IMG_H            = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        w_we,
  input  logic [4:0]                  w_addr,
  input  logic [weight_bits-1:0]      w_data,
  input  logic                        pix_valid,
  input  logic [pic_bits-1:0]         pix_data,
  output logic                        pix_ready,
  output logic [conv_result_bits-1:0] products [24:0],
  output logic                        prod_valid,
  output logic [$clog2(IMG_H)-1:0]    out_row,
  output logic [$clog2(IMG_W)-1:0]    out_col,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int NTAPS = kernel_size * kernel_size;
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int CRB   = conv_result_bits;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(kernel_size - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(kernel_size - 1);
  localparam logic [4:0]    W_COUNT  = 5'(NTAPS);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                  state_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic [weight_bits-1:0]  weight_q [NTAPS];
  logic [pic_bits-1:0]     win_q    [kernel_size][kernel_size];
  logic [pic_bits-1:0]     win_d    [kernel_size][kernel_size];
  logic [pic_bits-1:0]     lb_q     [kernel_size-1][IMG_W];
  logic [CRB-1:0]          prod_q   [24:0];
  logic [CRB-1:0]          prod_d   [24:0];
  logic                    prod_valid_q;
  logic [RW-1:0]           out_row_q;
  logic [CW-1:0]           out_col_q;

  logic accept;
  logic win_fire;

  assign accept   = (state_q == STREAM) && pix_valid;
  assign win_fire = accept && (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);

  // Signed weight times unsigned pixel, both widened to the product width.
  function automatic logic [CRB-1:0] mul(input logic [weight_bits-1:0] w,
                                         input logic [pic_bits-1:0]    p);
    logic signed [CRB-1:0] w_ext;
    logic signed [CRB-1:0] p_ext;
    w_ext = {{(CRB-weight_bits){w[weight_bits-1]}}, w};
    p_ext = {{(CRB-pic_bits){1'b0}}, p};
    return w_ext * p_ext;
  endfunction

  // Frame FSM and raster position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= STREAM;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        STREAM: begin
          if (pix_valid) begin
            if (row_q == ROW_LAST && col_q == COL_LAST) state_q <= DONE;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Weight store: writable only between frames, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) weight_q[k] <= '0;
    end else if (state_q == IDLE && w_we && w_addr < W_COUNT) begin
      weight_q[w_addr] <= w_data;
    end
  end

  // Next window: shift left, new right column = line buffers then live pixel.
  // NOTE: every variable written here gets a value on every path, so no latch.
  always_comb begin
    for (int i = 0; i < kernel_size; i++) begin
      for (int j = 0; j < kernel_size - 1; j++) win_d[i][j] = win_q[i][j+1];
      win_d[i][kernel_size-1] = (i < kernel_size - 1) ? lb_q[i][col_q] : pix_data;
    end
  end

  // Products of the next window against the weights, tap k = i*5+j.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      prod_d[k] = mul(weight_q[k], win_d[k / kernel_size][k % kernel_size]);
    end
  end

  // Window, line buffers and registered product outputs.
  // NOTE: line buffers are reset explicitly because reset must clear them;
  // this rules out mapping them to reset-less RAM macros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_valid_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      for (int k = 0; k < NTAPS; k++) prod_q[k] <= '0;
      for (int i = 0; i < kernel_size; i++)
        for (int j = 0; j < kernel_size; j++) win_q[i][j] <= '0;
      for (int m = 0; m < kernel_size - 1; m++)
        for (int x = 0; x < IMG_W; x++) lb_q[m][x] <= '0;
    end else begin
      prod_valid_q <= win_fire;
      if (accept) begin
        win_q <= win_d;
        for (int m = 0; m < kernel_size - 2; m++) lb_q[m][col_q] <= lb_q[m+1][col_q];
        lb_q[kernel_size-2][col_q] <= pix_data;
      end
      if (win_fire) begin
        prod_q    <= prod_d;
        out_row_q <= row_q - ROW_EDGE;
        out_col_q <= col_q - COL_EDGE;
      end
    end
  end

  assign pix_ready  = (state_q == STREAM);
  assign busy       = (state_q == STREAM);
  assign frame_done = (state_q == DONE);
  assign prod_valid = prod_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign products   = prod_q;

endmodule

// File: tb/tb_conv_window_product_gen.sv
// Directed bench for conv_window_product_gen on an 8x8 image.
module tb_conv_window_product_gen;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int CRB   = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           w_we;
  logic [4:0]     w_addr;
  logic [2:0]     w_data;
  logic           pix_valid;
  logic [1:0]     pix_data;
  logic           pix_ready;
  logic [CRB-1:0] products [24:0];
  logic           prod_valid;
  logic [2:0]     out_row;
  logic [2:0]     out_col;
  logic           busy;
  logic           frame_done;

  int checks = 0;
  int errors = 0;
  int wt [25];

  conv_window_product_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_we(w_we), .w_addr(w_addr),
    .w_data(w_data), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .products(products), .prod_valid(prod_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix_at(input int pat, input int r, input int c);
    return (pat == 0) ? 3 : (r + c) % 4;
  endfunction

  function automatic logic [CRB-1:0] exp_prod(input int pat, input int orow,
                                              input int ocol, input int k);
    int v;
    v = wt[k] * pix_at(pat, orow + k / 5, ocol + k % 5);
    return CRB'(v);
  endfunction

  task automatic load_weights();
    for (int k = 0; k < 25; k++) begin
      w_we = 1'b1; w_addr = 5'(k); w_data = 3'(wt[k]);
      step();
    end
    // Out-of-range addresses must not disturb any tap.
    for (int a = 25; a < 32; a++) begin
      w_we = 1'b1; w_addr = 5'(a); w_data = 3'b111;
      step();
    end
    w_we = 1'b0;
  endtask

  // One full frame; checks every cycle's strobes against the image model.
  task automatic run_frame(input int pat, input bit gaps, input bit inject);
    int r, c, g, obs_wins;
    logic exp_v, exp_done;
    logic [CRB-1:0] last_p12;
    obs_wins = 0;
    last_p12 = products[12];
    start = 1'b1; step(); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("pix_ready_after_start", pix_ready, 1);
    for (int idx = 0; idx < IMG_W * IMG_H; idx++) begin
      r = idx / IMG_W;
      c = idx % IMG_W;
      if (gaps) begin
        g = $urandom_range(1, 3);
        for (int q = 0; q < g; q++) begin
          pix_valid = 1'b0; pix_data = 2'($urandom_range(0, 3));
          step();
          check("gap_prod_valid", prod_valid, 0);
          check("gap_products_hold", products[12], last_p12);
        end
      end
      pix_valid = 1'b1;
      pix_data  = 2'(pix_at(pat, r, c));
      if (inject && idx == 10) begin
        w_we = 1'b1; w_addr = 5'd0; w_data = 3'd3; start = 1'b1;
      end
      step();
      w_we = 1'b0; start = 1'b0; pix_valid = 1'b0;
      exp_v    = (r >= 4 && c >= 4);
      exp_done = (idx == IMG_W * IMG_H - 1);
      check("prod_valid", prod_valid, exp_v);
      check("frame_done", frame_done, exp_done);
      check("busy", busy, !exp_done);
      if (prod_valid === 1'b1) obs_wins++;
      if (exp_v) begin
        check("out_row", out_row, r - 4);
        check("out_col", out_col, c - 4);
        for (int k = 0; k < 25; k++) check($sformatf("product[%0d]", k), products[k],
                                           exp_prod(pat, r - 4, c - 4, k));
        last_p12 = exp_prod(pat, r - 4, c - 4, 12);
      end
    end
    check("window_count", obs_wins, (IMG_H - 4) * (IMG_W - 4));
    // Start during DONE is ignored.
    start = 1'b1; step(); start = 1'b0;
    check("idle_frame_done", frame_done, 0);
    check("idle_prod_valid", prod_valid, 0);
    check("done_start_ignored_busy", busy, 0);
    step();
    check("idle_busy", busy, 0);
    check("idle_pix_ready", pix_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    pix_valid = 1'b0; pix_data = '0;
    step(); step();
    check("rst_prod_valid", prod_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_product0", products[0], 0);
    check("rst_product24", products[24], 0);
    rst_n = 1'b1;
    step();

    // All-ones weights, constant pixels of 3.
    for (int k = 0; k < 25; k++) wt[k] = 1;
    load_weights();
    run_frame(0, 1'b0, 1'b0);

    // Single centre tap of -4, diagonal pattern.
    for (int k = 0; k < 25; k++) wt[k] = 0;
    wt[12] = -4;
    load_weights();
    run_frame(1, 1'b0, 1'b0);

    // Same stream with gaps, plus writes and start attempted mid-frame.
    run_frame(1, 1'b1, 1'b1);

    // Reset mid-frame after 20 accepted pixels.
    start = 1'b1; step(); start = 1'b0;
    for (int idx = 0; idx < 20; idx++) begin
      pix_valid = 1'b1; pix_data = 2'(pix_at(1, idx / IMG_W, idx % IMG_W));
      step();
    end
    pix_valid = 1'b0; rst_n = 1'b0;
    step();
    check("midrst_prod_valid", prod_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    step();

    // Weights are cleared by reset: every product of a fresh frame is zero.
    for (int k = 0; k < 25; k++) wt[k] = 0;
    run_frame(1, 1'b0, 1'b0);

    // Reload a full signed range of weights and run once more.
    for (int k = 0; k < 25; k++) wt[k] = (k % 8) - 4;
    load_weights();
    run_frame(1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
